lc_token_store: RTL and testbench
=================================

Name: lc_token_store

Overview:
- Parametrised lifecycle token store: volatile, write-once-per-boot bank of DEPTH wide entries.
- Programmed by the provisioning sequencer after reset; read back by lifecycle/crypto consumers over a narrow beat-serialised response bus.
- Adds program-once semantics, global lock, error signalling, and valid/ready backpressure on both request and response.

Parameters:
WIDTH, 512, bits per token entry; must be a multiple of BUS_W
DEPTH, 8, number of entries; entry 0 is the hardwired all-zero token
BUS_W, 64, response data bus width; BEATS = WIDTH/BUS_W
ADDR_W, 3, address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid&&req_ready
req_op  in  1  0=read, 1=program
req_addr  in  ADDR_W  entry index
req_wdata  in  WIDTH  program data
lock_req  in  1  one-cycle pulse; sets sticky global lock
rsp_valid  out  1  response beat valid
rsp_ready  in  1  response beat consumed when rsp_valid&&rsp_ready
rsp_data  out  BUS_W  response beat data
rsp_last  out  1  final beat of response
rsp_err  out  1  error flag, constant across all beats of a response
prog_mask  out  DEPTH  bit i set = entry i programmed (bit 0 always 1)
locked  out  1  global lock status

Behaviour:
- Reset (async): all entries cleared to 0; prog_mask=1 (bit 0 only); locked=0; FSM=IDLE; rsp_valid=0, rsp_data=0, rsp_last=0, rsp_err=0; req_ready=1. Reset mid-response drops the response; no beat is emitted after deassertion.
- FSM states: IDLE, RD_STREAM, PRG_RSP. req_ready=1 only in IDLE; one request outstanding.
- Read accept (edge T): entry copied to response shift register; FSM->RD_STREAM. From T+1: rsp_valid=1, beat 0 = bits [BUS_W-1:0], LSB beat first.
  - Each rsp handshake advances one beat. rsp_data/rsp_last/rsp_err hold stable while rsp_ready=0.
  - rsp_last=1 on beat BEATS-1. Its handshake returns FSM to IDLE; req_ready=1 the next cycle.
- Read errors: addr>=DEPTH, or entry unprogrammed (prog_mask bit 0 for addr>0).
  - Single beat: rsp_data=0, rsp_last=1, rsp_err=1.
  - Reading entry 0 is legal: BEATS zero beats, rsp_err=0.
- Program accept (edge T): write occurs on edge T only if addr<DEPTH, addr!=0, entry unprogrammed, and locked=0. Entry<=req_wdata and prog_mask[addr]<=1.
  - Otherwise no state changes.
  - FSM->PRG_RSP: single beat from T+1 with rsp_data=0, rsp_last=1, rsp_err=!write_ok; held until handshake, then IDLE.
- Lock: lock_req sets locked on next edge, sticky until reset. Reads are unaffected.
  - lock_req in the same cycle as a program accept: the program completes (lock check uses pre-edge value).
- No latency guarantee beyond these: read response first beat exactly 1 cycle after accept with rsp_ready held high; full read = BEATS cycles.
- rsp_valid never drops without a handshake or reset.

Test Plan:
- Reset -> prog_mask=8'h01, locked=0, rsp_valid=0, req_ready=1; read addr 0 -> 8 beats of 64'h0, rsp_last only on beat 7, rsp_err=0.
- Program addr 3 with 512'h33a3...a24a repeated pattern -> single ack beat rsp_err=0, prog_mask=8'h09; read addr 3 with rsp_ready=1 -> 8 consecutive beats, LSB 64-bit word first, matching data.
- Second program of addr 3 with 512'h1 -> rsp_err=1, contents unchanged on readback; program addr 0 -> rsp_err=1; read addr 5 (blank) -> one beat, data 0, last=1, err=1.
- Read addr 3 with rsp_ready toggling 1/0 every cycle -> rsp_data stable during stalls, exactly 8 beats, req_ready low until last handshake.
- Pulse lock_req, then program addr 4 -> rsp_err=1, prog_mask bit 4 stays 0, locked=1; read addr 3 still succeeds.
- Lock pulse coincident with program accept to addr 6 -> write succeeds (err=0); assert rst_n low mid-read at beat 4 -> rsp_valid=0 immediately, prog_mask=8'h01, read addr 3 then returns err=1.

Source files
------------

// File: rtl/lc_token_store_if.sv
// Request/response bus of the lifecycle token store.
// The master issues one request at a time and drains beat-serialised responses.
interface lc_token_store_if #(
    parameter int WIDTH  = 512,
    parameter int BUS_W  = 64,
    parameter int ADDR_W = 3
);
    logic              req_valid;
    logic              req_ready;
    logic              req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [WIDTH-1:0]  req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [BUS_W-1:0]  rsp_data;
    logic              rsp_last;
    logic              rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
    );
endinterface

// File: rtl/lc_token_store.sv
// Volatile write-once token bank: entry 0 reads as zero, other entries program once per boot,
// reads stream out LSB beat first; a sticky lock blocks further programming.
module lc_token_store #(
    parameter int WIDTH  = 512,
    parameter int DEPTH  = 8,
    parameter int BUS_W  = 64,
    parameter int ADDR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    lc_token_store_if.slave  bus,
    input  logic             lock_req,
    output logic [DEPTH-1:0] prog_mask,
    output logic             locked
);
    localparam int BEATS  = WIDTH / BUS_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    if (WIDTH % BUS_W != 0) begin : g_bad_width
        $error("WIDTH must be a multiple of BUS_W");
    end
    if ((2 ** ADDR_W) < DEPTH) begin : g_bad_addr
        $error("ADDR_W too narrow for DEPTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_STREAM,
        ST_PRG_RSP
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [DEPTH-1:0]   prog_mask_q, prog_mask_d;
    logic               locked_q, locked_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               err_q, err_d;

    logic req_fire;
    logic rsp_fire;
    logic addr_ok;
    logic entry_prog;
    logic rd_ok;
    logic wr_ok;

    assign req_fire   = bus.req_valid && bus.req_ready;
    assign rsp_fire   = bus.rsp_valid && bus.rsp_ready;
    assign addr_ok    = {1'b0, bus.req_addr} < (ADDR_W + 1)'(DEPTH);
    assign entry_prog = addr_ok && prog_mask_q[bus.req_addr];
    // Entry 0 carries a permanently set mask bit, so it always reads as a legal all-zero token.
    assign rd_ok      = entry_prog;
    assign wr_ok      = addr_ok && (bus.req_addr != '0) && !entry_prog && !locked_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        mem_d       = mem_q;
        prog_mask_d = prog_mask_q;
        locked_d    = locked_q | lock_req;
        shift_d     = shift_q;
        beat_d      = beat_q;
        err_d       = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    if (!bus.req_op) begin
                        state_d = ST_RD_STREAM;
                        if (rd_ok) begin
                            shift_d = mem_q[bus.req_addr];
                            beat_d  = '0;
                            err_d   = 1'b0;
                        end else begin
                            // Error reads collapse to one zero beat that is already the last one.
                            shift_d = '0;
                            beat_d  = LAST_BEAT;
                            err_d   = 1'b1;
                        end
                    end else begin
                        state_d = ST_PRG_RSP;
                        shift_d = '0;
                        err_d   = !wr_ok;
                        if (wr_ok) begin
                            mem_d[bus.req_addr]       = bus.req_wdata;
                            prog_mask_d[bus.req_addr] = 1'b1;
                        end
                    end
                end
            end
            ST_RD_STREAM: begin
                if (rsp_fire) begin
                    shift_d = shift_q >> BUS_W;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            ST_PRG_RSP: begin
                if (rsp_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the bank must come up cleared after every reset, so it lives in resettable flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            prog_mask_q <= DEPTH'(1);
            locked_q    <= 1'b0;
            shift_q     <= '0;
            beat_q      <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: state updates use non-blocking assignment so all flops sample pre-edge values together.
            state_q     <= state_d;
            prog_mask_q <= prog_mask_d;
            locked_q    <= locked_d;
            shift_q     <= shift_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            mem_q       <= mem_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q != ST_IDLE);
    assign bus.rsp_data  = shift_q[BUS_W-1:0];
    assign bus.rsp_last  = (state_q == ST_PRG_RSP) ||
                           ((state_q == ST_RD_STREAM) && (beat_q == LAST_BEAT));
    assign bus.rsp_err   = err_q;
    assign prog_mask     = prog_mask_q;
    assign locked        = locked_q;
endmodule

// File: tb/tb_lc_token_store.sv
// Bench for lc_token_store: fixed vector table, hand-written corner sequences,
// then randomised traffic against an array-based model of the token bank.
module tb_lc_token_store;
    localparam int WIDTH  = 512;
    localparam int DEPTH  = 8;
    localparam int BUS_W  = 64;
    localparam int ADDR_W = 3;
    localparam int BEATS  = WIDTH / BUS_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             lock_req = 1'b0;
    logic [DEPTH-1:0] prog_mask;
    logic             locked;

    lc_token_store_if #(.WIDTH(WIDTH), .BUS_W(BUS_W), .ADDR_W(ADDR_W)) bus ();

    lc_token_store #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BUS_W(BUS_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .lock_req  (lock_req),
        .prog_mask (prog_mask),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Beats captured from the most recent response.
    logic [BUS_W-1:0] rx_data[$];
    bit               rx_last[$];
    bit               rx_err[$];
    int               rx_cycles;

    // Reference model: plain arrays of token contents and programmed flags.
    logic [WIDTH-1:0] m_mem [DEPTH];
    bit               m_prog [DEPTH];
    bit               m_locked;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_prog[i] = (i == 0);
        end
        m_locked = 1'b0;
    endfunction

    function automatic logic [DEPTH-1:0] model_mask();
        logic [DEPTH-1:0] m;
        for (int i = 0; i < DEPTH; i++) m[i] = m_prog[i];
        return m;
    endfunction

    function automatic bit model_read_err(input int addr);
        return (addr >= DEPTH) || !m_prog[addr];
    endfunction

    function automatic bit model_program(input int addr, input logic [WIDTH-1:0] wdata, input bit lock_now);
        bit ok;
        ok = (addr < DEPTH) && (addr != 0) && !m_prog[addr] && !m_locked;
        if (ok) begin
            m_mem[addr]  = wdata;
            m_prog[addr] = 1'b1;
        end
        m_locked = m_locked | lock_now;
        return !ok;
    endfunction

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b0;
        lock_req       = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_prog_mask", prog_mask, 8'h01);
        check("rst_locked", locked, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_rsp_flags", {bus.rsp_data, bus.rsp_last, bus.rsp_err}, 0);
        model_reset();
    endtask

    // Called and returns at a falling edge; the request is accepted on the rising edge in between.
    task automatic send_req(input bit op, input logic [ADDR_W-1:0] addr,
                            input logic [WIDTH-1:0] wdata, input bit lock);
        int w = 0;
        while (!bus.req_ready && w < 32) begin
            @(negedge clk);
            w++;
        end
        check("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        lock_req      = lock;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lock_req      = 1'b0;
        check("rsp_valid_t1", bus.rsp_valid, 1);
    endtask

    // mode 0: ready always high, 1: ready toggles 1/0, 2: random ready.
    task automatic collect(input int mode, input int max_beats);
        bit               prev_stall = 1'b0;
        logic [BUS_W+1:0] prev_val = '0;
        bit               done = 1'b0;
        rx_data.delete();
        rx_last.delete();
        rx_err.delete();
        rx_cycles = 0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            if (mode == 0)      bus.rsp_ready = 1'b1;
            else if (mode == 1) bus.rsp_ready = (cyc % 2 == 0);
            else                bus.rsp_ready = 1'($urandom_range(0, 1));
            if (!bus.rsp_valid) begin
                check("rsp_valid_held", bus.rsp_valid, 1);
                break;
            end
            if (prev_stall) begin
                check("rsp_stable", {bus.rsp_data, bus.rsp_last, bus.rsp_err}, prev_val);
                check("req_ready_busy", bus.req_ready, 0);
            end
            rx_cycles++;
            prev_val   = {bus.rsp_data, bus.rsp_last, bus.rsp_err};
            prev_stall = !bus.rsp_ready;
            if (bus.rsp_ready) begin
                rx_data.push_back(bus.rsp_data);
                rx_last.push_back(bus.rsp_last);
                rx_err.push_back(bus.rsp_err);
                done = bus.rsp_last;
            end
            @(posedge clk);
            @(negedge clk);
            if (done || rx_data.size() == max_beats) break;
        end
        bus.rsp_ready = 1'b0;
        if (done) check("req_ready_after", bus.req_ready, 1);
        else if (rx_data.size() != max_beats) check("rsp_timeout", 0, 1);
    endtask

    task automatic check_read(input string name, input bit exp_err, input logic [WIDTH-1:0] exp_data);
        int nb = exp_err ? 1 : BEATS;
        check({name, "_beats"}, rx_data.size(), nb);
        for (int i = 0; i < rx_data.size() && i < nb; i++) begin
            check({name, "_data"}, rx_data[i], exp_err ? '0 : exp_data[i*BUS_W +: BUS_W]);
            check({name, "_last"}, rx_last[i], (i == nb - 1));
            check({name, "_err"}, rx_err[i], exp_err);
        end
    endtask

    task automatic check_prog(input string name, input bit exp_err);
        check({name, "_beats"}, rx_data.size(), 1);
        if (rx_data.size() > 0) begin
            check({name, "_data"}, rx_data[0], 0);
            check({name, "_last"}, rx_last[0], 1);
            check({name, "_err"}, rx_err[0], exp_err);
        end
    endtask

    typedef struct {
        bit               op;
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0] wdata;
        bit               exp_err;
        logic [WIDTH-1:0] exp_rd;
        logic [DEPTH-1:0] exp_mask;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit expected bench completion");
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] pat_p;
        logic [WIDTH-1:0] pat_q;
        logic [WIDTH-1:0] pat_r;
        logic [WIDTH-1:0] one;
        vec_t             vecs[$];

        pat_p = {8{64'h33a3_5c1e_9d07_a24a}};
        pat_q = {64'h8888_0000_8888_0008, 64'h7777_0000_7777_0007, 64'h6666_0000_6666_0006,
                 64'h5555_0000_5555_0005, 64'h4444_0000_4444_0004, 64'h3333_0000_3333_0003,
                 64'h2222_0000_2222_0002, 64'h1111_0000_1111_0001};
        pat_r = {16{32'hc0de_6006}};
        one   = 512'h1;

        vecs.push_back('{0, 3'd0, '0,    0, '0,    8'h01});
        vecs.push_back('{1, 3'd3, pat_p, 0, '0,    8'h09});
        vecs.push_back('{0, 3'd3, '0,    0, pat_p, 8'h09});
        vecs.push_back('{1, 3'd3, one,   1, '0,    8'h09});
        vecs.push_back('{0, 3'd3, '0,    0, pat_p, 8'h09});
        vecs.push_back('{1, 3'd0, pat_q, 1, '0,    8'h09});
        vecs.push_back('{0, 3'd5, '0,    1, '0,    8'h09});
        vecs.push_back('{1, 3'd7, pat_q, 0, '0,    8'h89});
        vecs.push_back('{0, 3'd7, '0,    0, pat_q, 8'h89});

        do_reset();

        foreach (vecs[i]) begin
            send_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, 1'b0);
            collect(0, 16);
            if (vecs[i].op) begin
                check_prog("vec_prog", vecs[i].exp_err);
            end else begin
                check_read("vec_read", vecs[i].exp_err, vecs[i].exp_rd);
                check("vec_read_cycles", rx_cycles, vecs[i].exp_err ? 1 : BEATS);
            end
            check("vec_mask", prog_mask, vecs[i].exp_mask);
        end

        // Read with rsp_ready toggling: stalls must hold the beat and keep req_ready low.
        send_req(0, 3'd3, '0, 1'b0);
        collect(1, 16);
        check_read("stall_rd3", 0, pat_p);

        // Idle lock pulse, then a program that must be refused.
        lock_req = 1'b1;
        @(negedge clk);
        lock_req = 1'b0;
        check("lock_set", locked, 1);
        send_req(1, 3'd4, pat_r, 1'b0);
        collect(0, 16);
        check_prog("locked_prog4", 1);
        check("locked_mask", prog_mask, 8'h89);
        send_req(0, 3'd3, '0, 1'b0);
        collect(0, 16);
        check_read("locked_rd3", 0, pat_p);

        // Lock pulse coincident with a program accept: the write still lands.
        do_reset();
        send_req(1, 3'd3, pat_p, 1'b0);
        collect(0, 16);
        check_prog("re_prog3", 0);
        send_req(1, 3'd6, pat_r, 1'b1);
        collect(0, 16);
        check_prog("lockedge_prog6", 0);
        check("lockedge_locked", locked, 1);
        check("lockedge_mask", prog_mask, 8'h49);
        send_req(0, 3'd6, '0, 1'b0);
        collect(0, 16);
        check_read("lockedge_rd6", 0, pat_r);

        // Reset while beat 4 of a read is on the bus.
        send_req(0, 3'd3, '0, 1'b0);
        collect(0, 4);
        check("midrst_beats", rx_data.size(), 4);
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", bus.rsp_valid, 0);
        check("midrst_mask", prog_mask, 8'h01);
        check("midrst_locked", locked, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_no_beat", bus.rsp_valid, 0);
        check("midrst_req_ready", bus.req_ready, 1);
        model_reset();
        send_req(0, 3'd3, '0, 1'b0);
        collect(0, 16);
        check_read("midrst_rd3", 1, '0);

        // Randomised traffic against the model.
        do_reset();
        for (int n = 0; n < 60; n++) begin
            bit               op;
            int               addr;
            bit               lk;
            bit               exp_err;
            logic [WIDTH-1:0] wd;
            op   = 1'($urandom_range(0, 1));
            addr = $urandom_range(0, DEPTH - 1);
            lk   = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < WIDTH / 32; k++) wd[k*32 +: 32] = $urandom;
            if (op) begin
                exp_err = model_program(addr, wd, lk);
                send_req(1, ADDR_W'(addr), wd, lk);
                collect(2, 16);
                check_prog("rand_prog", exp_err);
            end else begin
                exp_err  = model_read_err(addr);
                m_locked = m_locked | lk;
                send_req(0, ADDR_W'(addr), wd, lk);
                collect(2, 16);
                check_read("rand_read", exp_err, m_mem[addr]);
            end
            check("rand_mask", prog_mask, model_mask());
            check("rand_locked", locked, m_locked);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
